// File: rtl/llama_layer_mul_rr_sched.sv
// Round-robin share of one signed x unsigned multiplier; 2-cycle accept-to-response latency, 1/cycle.
// Backpressure: rsp_ready low with both stages full drops every req_ready in the same cycle.
module llama_layer_mul_rr_sched #(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int AW   = 25,
    parameter int BW   = 39,
    parameter int PW   = 63
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*AW-1:0] req_a,
    input  logic [NREQ*BW-1:0] req_b,
    output logic [AW-1:0]     mul_din0,
    output logic [BW-1:0]     mul_din1,
    input  logic [PW-1:0]     mul_dout,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [PW-1:0]     rsp_data,
    output logic              busy
);

    logic              s1_vld_q, s1_vld_d;
    logic [AW-1:0]     s1_a_q, s1_a_d;
    logic [BW-1:0]     s1_b_q, s1_b_d;
    logic [IDW-1:0]    s1_id_q, s1_id_d;
    logic              s2_vld_q, s2_vld_d;
    logic [PW-1:0]     s2_data_q, s2_data_d;
    logic [IDW-1:0]    s2_id_q, s2_id_d;
    logic [IDW-1:0]    last_gnt_q, last_gnt_d;

    logic              s1_adv, s2_adv;
    logic              win_vld;
    logic [IDW-1:0]    win_idx;
    logic [IDW-1:0]    cand;
    logic              accept;

    assign s2_adv = !s2_vld_q || rsp_ready;
    assign s1_adv = !s1_vld_q || s2_adv;

    // Search starts just past the last grant so the most recent winner has lowest priority.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDW'((int'(last_gnt_q) + k) % NREQ);
            if (!win_vld && req_valid[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (win_vld && s1_adv && !ap_rst) begin
            req_ready[win_idx] = 1'b1;
        end
    end

    assign accept = |(req_valid & req_ready);

    always_comb begin
        s1_vld_d   = s1_vld_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_id_d    = s1_id_q;
        s2_vld_d   = s2_vld_q;
        s2_data_d  = s2_data_q;
        s2_id_d    = s2_id_q;
        last_gnt_d = last_gnt_q;
        if (s1_adv) begin
            s1_vld_d = accept;
            if (accept) begin
                s1_a_d     = req_a[int'(win_idx)*AW +: AW];
                s1_b_d     = req_b[int'(win_idx)*BW +: BW];
                s1_id_d    = win_idx;
                last_gnt_d = win_idx;
            end
        end
        if (s2_adv) begin
            s2_vld_d = s1_vld_q;
            if (s1_vld_q) begin
                s2_data_d = mul_dout;
                s2_id_d   = s1_id_q;
            end
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            s1_vld_q   <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_id_q    <= '0;
            s2_vld_q   <= 1'b0;
            s2_data_q  <= '0;
            s2_id_q    <= '0;
            last_gnt_q <= IDW'(NREQ - 1);
        end else begin
            s1_vld_q   <= s1_vld_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_id_q    <= s1_id_d;
            s2_vld_q   <= s2_vld_d;
            s2_data_q  <= s2_data_d;
            s2_id_q    <= s2_id_d;
            last_gnt_q <= last_gnt_d;
        end
    end

    assign mul_din0  = s1_a_q;
    assign mul_din1  = s1_b_q;
    assign rsp_valid = s2_vld_q;
    assign rsp_data  = s2_data_q;
    assign rsp_id    = s2_id_q;
    assign busy      = s1_vld_q || s2_vld_q;

endmodule

// File: doc/llama_layer_mul_rr_sched.md
Name: llama_layer_mul_rr_sched

Overview:
- Shares one combinational 25-bit signed x 39-bit unsigned multiplier (63-bit product) among NREQ requesters inside llama_layer, e.g. the Q/K/V/O dequant-scale paths.
- Round-robin arbitration with a valid/ready handshake per requester.
- Two-stage pipeline: operand register, then product register.
- Each response is tagged with the ID of the requester that issued it.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of the response ID; must equal clog2(NREQ).
- AW, 25, operand A width (signed).
- BW, 39, operand B width (unsigned).
- PW, 63, product width.

Ports:
- ap_clk  in  1  clock; all state updates on the rising edge.
- ap_rst  in  1  reset: synchronous, active-high.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; at most one bit high per cycle.
- req_a  in  NREQ*AW  flattened A operands; requester i uses bits [i*AW +: AW].
- req_b  in  NREQ*BW  flattened B operands; requester i uses bits [i*BW +: BW].
- mul_din0  out  AW  to the shared multiplier din0; driven from the stage-1 A register.
- mul_din1  out  BW  to the shared multiplier din1; driven from the stage-1 B register.
- mul_dout  in  PW  from the shared multiplier (combinational).
- rsp_valid  out  1  product valid.
- rsp_ready  in  1  downstream accept.
- rsp_id  out  IDW  requester index of the product.
- rsp_data  out  PW  product.
- busy  out  1  high when stage 1 or stage 2 holds data.

Behaviour:
- Reset (ap_rst high at a clock edge):
  - s1_vld, s2_vld, rsp_valid and busy go to 0.
  - mul_din0, mul_din1, rsp_id and rsp_data go to 0.
  - Round-robin pointer last_gnt goes to NREQ-1, so requester 0 has first priority.
  - req_ready is 0 while ap_rst is high.
  - Reset mid-operation discards all in-flight products; no response is issued for them.
- Pipeline control:
  - s2_adv = !s2_vld | rsp_ready.
  - s1_adv = !s1_vld | s2_adv.
  - Arbitration happens only when s1_adv = 1.
- Arbitration (combinational):
  - Search req_valid starting at index (last_gnt+1) mod NREQ and wrapping; the first set bit wins.
  - req_ready[win] = 1 only when s1_adv = 1. All other req_ready bits are 0.
  - A requester sees req_ready independent of its own req_valid only via the winner selection; ready is never asserted without valid.
- Accept (req_valid[i] & req_ready[i]):
  - Stage 1 captures A_i, B_i and id = i; s1_vld is set.
  - last_gnt is updated to i.
- No accept while s1_adv = 1: s1_vld is cleared.
- Stage 1 to stage 2: when s1_vld & s2_adv, stage 2 captures mul_dout and the id; s2_vld is set.
- Stage 2 with s2_adv and !s1_vld: s2_vld is cleared.
- Outputs:
  - rsp_valid = s2_vld.
  - rsp_data and rsp_id are held stable while rsp_valid & !rsp_ready.
- Latency and throughput:
  - Accept at cycle T gives rsp_valid at T+2 with no backpressure.
  - Throughput is one product per cycle.
  - A full stall (rsp_ready = 0 with both stages full) deasserts all req_ready the same cycle.
- Arithmetic:
  - Product = signed(A) * {1'b0, B}, truncated to the low 63 bits (two's-complement wrap).
  - The scheduler never modifies the product; the product is whatever mul_dout returns.
- Fairness: with all requesters continuously valid and no backpressure, grants rotate 0,1,2,3,0,... A requester waits at most NREQ-1 grants.
- Simultaneous events in the same cycle:
  - A new accept into stage 1, stage 1 advancing to stage 2 and stage 2 draining to the output all occur together.
  - No bubble is inserted.

Test Plan:
- Reset then single request: req0 with A=-3, B=5 -> rsp_valid 2 cycles later, rsp_id=0, rsp_data=63'h7FFF_FFFF_FFFF_FFF1 (-15). busy=1 across those cycles, then 0.
- All four requesters valid continuously, rsp_ready=1, A_i=i+1, B_i=10 -> grants in order 0,1,2,3,0; responses back-to-back with ids 0,1,2,3 and data 10,20,30,40.
- Backpressure: rsp_ready=0 for 5 cycles during the stream -> no more than 2 products in flight. rsp_data and rsp_id are held stable. All req_ready=0 after both stages fill. No loss or duplication after release.
- Extremes: A=-2^24, B=2^39-1 -> rsp_data equals the low 63 bits of -2^24*(2^39-1). A=2^24-1, B=0 -> rsp_data=0.
- Sparse fairness: only req1 and req3 valid, last_gnt=1 -> req3 is granted next, then req1; req0 and req2 never see req_ready=1.
- Reset mid-operation: assert ap_rst with both stages full -> next cycle rsp_valid=0 and busy=0. After reset, req0 has first priority and no stale response appears.
